com_fb_writer: RTL and testbench
================================

COM_FB_WRITER -- requirements
Module: com_fb_writer

Interface
REQ-001 Parameter ADDR_LIMIT, default 18'd153600, number of valid framebuffer word addresses (0..ADDR_LIMIT-1).
REQ-002 Parameter DEPTH, default 8, FIFO depth in entries, power of two.
REQ-003 clk  in  1  single system clock (300 MHz); all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 in_stb  in  1  one-cycle strobe; in_addr/in_data valid this cycle; no back-pressure possible.
REQ-006 in_addr  in  18  word address from the serial receiver.
REQ-007 in_data  in  48  assembled 6-byte word.
REQ-008 clr  in  1  synchronous clear: flush FIFO and output stage, clear flags.
REQ-009 cmd_valid  out  1  write command to PSRAM controller valid.
REQ-010 cmd_ready  in  1  PSRAM controller accepts command when high together with cmd_valid.
REQ-011 cmd_addr  out  18  write address.
REQ-012 cmd_data  out  48  write data.
REQ-013 frame_done  out  1  one-cycle pulse when the word at ADDR_LIMIT-1 is accepted by the controller.
REQ-014 overflow  out  1  sticky: an in-range word was lost because the FIFO was full.
REQ-015 drop_cnt  out  8  saturating count of words rejected as out-of-range.

Function
REQ-016 in_stb with in_addr < ADDR_LIMIT and FIFO not full SHALL write {in_addr,in_data} into the FIFO in the same cycle.
REQ-017 in_stb with in_addr >= ADDR_LIMIT (including wrapped preamble addresses 18'h3FFF7..18'h3FFFF) SHALL be discarded and SHALL increment drop_cnt, saturating at 255.
REQ-018 in_stb with an in-range address while the FIFO is full SHALL be discarded and SHALL set overflow; FIFO contents are unchanged.
REQ-019 Output stage FSM has states IDLE (cmd_valid=0) and HOLD (cmd_valid=1).
REQ-020 IDLE -> HOLD when the FIFO is non-empty: pop the head into cmd_addr/cmd_data; cmd_valid rises 1 cycle after the FIFO becomes non-empty.
REQ-021 In HOLD, while cmd_ready=0, cmd_valid, cmd_addr and cmd_data SHALL stay stable.
REQ-022 In HOLD with cmd_ready=1 and FIFO non-empty: pop the next entry in the same cycle and stay in HOLD (one command per cycle sustained).
REQ-023 In HOLD with cmd_ready=1 and FIFO empty: go to IDLE.
REQ-024 Simultaneous push and pop on a full FIFO: the pop is evaluated first, so the push succeeds and overflow is not set.
REQ-025 Simultaneous push and pop on an empty FIFO with the FSM in IDLE: the word enters the FIFO and follows REQ-020 (no bypass).
REQ-026 FIFO pointers SHALL be log2(DEPTH)+1 bits and wrap naturally; full = MSBs differ and low bits equal.
REQ-027 frame_done SHALL pulse in the cycle after the handshake (cmd_valid & cmd_ready) with cmd_addr == ADDR_LIMIT-1.
REQ-028 clr SHALL override all other activity: next cycle FIFO empty, FSM IDLE, cmd_valid=0, overflow=0, drop_cnt=0, frame_done=0; any in_stb in the clr cycle is discarded and not counted.
REQ-029 Command order on cmd_* SHALL equal acceptance order on in_*.

Reset
REQ-030 While reset=0: FIFO empty, FSM IDLE, cmd_valid=0, cmd_addr=0, cmd_data=0, frame_done=0, overflow=0, drop_cnt=0.
REQ-031 Reset asserted mid-handshake SHALL drop cmd_valid immediately (asynchronously); pending entries are lost.
REQ-032 Reset release SHALL require no cycles before in_stb is accepted on the first clock edge.

Structure
REQ-033 Shared package com_pkg holds ADDR_W=18, DATA_W=48, the FSM state enum {IDLE, HOLD}, and the default ADDR_LIMIT.
REQ-034 The FIFO SHALL be a sub-module, com_sync_fifo (DEPTH x 66 bits, push/pop/full/empty); FSM, filtering and flags live in com_fb_writer.

Verification
REQ-035 Reset, then 9 strobes at 18'h3FFF7..18'h3FFFF then addr 0, data 48'h0102030405 06 -> drop_cnt=9; one command addr 0 with matching data; overflow=0.
REQ-036 cmd_ready held 0, 9 in-range strobes with DEPTH=8 -> 1 word in output stage + 8 in FIFO... 9th accepted; 10th strobe sets overflow=1; release ready -> addresses 0..8 appear in order.
REQ-037 cmd_ready=1 continuously, strobe every cycle for 20 cycles -> 20 commands back-to-back, cmd_valid never drops after the first, no overflow.
REQ-038 Write addr ADDR_LIMIT-1 with ready=1 -> frame_done pulses exactly one cycle after the handshake; ADDR_LIMIT itself -> dropped, drop_cnt+1, no frame_done.
REQ-039 300 out-of-range strobes -> drop_cnt saturates at 255; clr -> drop_cnt=0, cmd_valid=0 next cycle.
REQ-040 Assert reset while cmd_valid=1 and ready=0 -> cmd_valid=0 without a clock edge; after release, FIFO empty and no stale command issued.

Source files
------------

// File: rtl/com_pkg.sv
// Shared types and constants for the framebuffer write path.
// Word layout is {addr, data}, 66 bits.
package com_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 48;

  localparam logic [ADDR_W-1:0] ADDR_LIMIT_DEF = 18'd153600;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } word_t;

endpackage

// File: rtl/com_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and a combinational head.
// Push/pop legality is decided by the owner.
module com_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 66
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/com_fb_writer.sv
// Filters receiver words by address, buffers them and issues
// one PSRAM write command per cycle through a valid/ready stage.
module com_fb_writer
  import com_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_LIMIT_DEF,
  parameter int                DEPTH      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_stb,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clr,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data,
  output logic              frame_done,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_LIMIT - 1'b1;

  state_t state;
  state_t state_nxt;
  word_t  head;
  logic   full;
  logic   empty;
  logic   pop;
  logic   push;
  logic   lost;
  logic   in_range;

  assign in_range = (in_addr < ADDR_LIMIT);

  // Pop is resolved first so a full FIFO can still take a push.
  assign push = in_stb && in_range && !clr && (!full || pop);
  assign lost = in_stb && in_range && !clr && full && !pop;

  com_sync_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(word_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .push  (push),
    .wdata ({in_addr, in_data}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (cmd_ready) begin
            if (!empty) pop = 1'b1;
            else state_nxt = IDLE;
          end
        end
      endcase
    end
  end

  assign cmd_valid = (state == HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cmd_addr   <= '0;
      cmd_data   <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      frame_done <= !clr && cmd_valid && cmd_ready &&
                    (cmd_addr == LAST);
      if (pop) begin
        cmd_addr <= head.addr;
        cmd_data <= head.data;
      end
      if (clr) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else begin
        if (lost) overflow <= 1'b1;
        if (in_stb && !in_range && drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_com_fb_writer.sv
// Randomized and directed bench for com_fb_writer against a
// queue-based reference model of the write path.
module tb_com_fb_writer;
  import com_pkg::*;

  localparam int          DEPTH = 8;
  localparam int          LIMIT = 153600;
  localparam logic [17:0] LAST  = 18'(LIMIT - 1);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_stb = 1'b0;
  logic [17:0] in_addr = '0;
  logic [47:0] in_data = '0;
  logic        clr = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [17:0] cmd_addr;
  logic [47:0] cmd_data;
  logic        frame_done;
  logic        overflow;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  com_fb_writer #(
    .ADDR_LIMIT (18'(LIMIT)),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_stb     (in_stb),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .clr        (clr),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .frame_done (frame_done),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  typedef struct {
    logic [17:0] a;
    logic [47:0] d;
  } ent_t;

  ent_t        q[$];
  bit          m_valid;
  logic [17:0] m_addr;
  logic [47:0] m_data;
  bit          m_ovf;
  bit          m_fd;
  int          m_drop;
  int          hs;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_valid = 0;
    m_addr  = '0;
    m_data  = '0;
    m_ovf   = 0;
    m_fd    = 0;
    m_drop  = 0;
  endfunction

  task automatic compare();
    check("cmd_valid", cmd_valid, m_valid);
    if (m_valid || !reset) begin
      check("cmd_addr", cmd_addr, m_addr);
      check("cmd_data", cmd_data, m_data);
    end
    check("frame_done", frame_done, m_fd);
    check("overflow", overflow, m_ovf);
    check("drop_cnt", drop_cnt, m_drop);
  endtask

  // Advance the model over one clock edge, then compare.
  task automatic step();
    ent_t e;
    if (cmd_valid && cmd_ready) hs++;
    if (!reset) begin
      model_reset();
    end else if (clr) begin
      q.delete();
      m_valid = 0;
      m_ovf   = 0;
      m_fd    = 0;
      m_drop  = 0;
    end else begin
      m_fd = m_valid && cmd_ready && (m_addr == LAST);
      if (m_valid && cmd_ready) m_valid = 0;
      if (!m_valid && q.size() > 0) begin
        e       = q.pop_front();
        m_valid = 1;
        m_addr  = e.a;
        m_data  = e.d;
      end
      if (in_stb) begin
        if (int'(in_addr) >= LIMIT) begin
          if (m_drop < 255) m_drop++;
        end else if (q.size() < DEPTH) begin
          q.push_back('{a: in_addr, d: in_data});
        end else begin
          m_ovf = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    in_stb = 1'b0;
    repeat (n) step();
  endtask

  task automatic strobe(input logic [17:0] a,
                        input logic [47:0] d);
    in_stb  = 1'b1;
    in_addr = a;
    in_data = d;
    step();
    in_stb  = 1'b0;
  endtask

  function automatic logic [47:0] rnd48();
    return {16'($urandom), $urandom};
  endfunction

  function automatic logic [17:0] rnd_oor();
    return 18'($urandom_range(LIMIT, 262143));
  endfunction

  initial begin
    model_reset();
    hs = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", cmd_valid, 0);
    check("rst_addr", cmd_addr, 0);
    check("rst_data", cmd_data, 0);
    check("rst_fd", frame_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    reset = 1'b1;

    // Preamble addresses dropped, then one real word.
    cmd_ready = 1'b1;
    for (int i = 0; i < 9; i++)
      strobe(18'h3FFF7 + 18'(i), rnd48());
    strobe(18'd0, 48'h010203040506);
    idle(3);
    check("preamble_drop", drop_cnt, 9);

    // Fill output stage plus FIFO, then overflow.
    cmd_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      strobe(18'(i), rnd48());
    check("ovf_set", overflow, 1);
    hs = 0;
    cmd_ready = 1'b1;
    idle(12);
    check("ovf_drain", hs, 9);

    // Sustained one command per cycle.
    clr = 1'b1;
    step();
    clr = 1'b0;
    hs = 0;
    for (int i = 0; i < 20; i++)
      strobe(18'(100 + i), rnd48());
    idle(4);
    check("b2b_count", hs, 20);

    // Last address pulses frame_done; limit is dropped.
    strobe(LAST, rnd48());
    idle(3);
    strobe(18'(LIMIT), rnd48());
    idle(3);

    // Drop counter saturation and clear.
    for (int i = 0; i < 300; i++)
      strobe(rnd_oor(), rnd48());
    check("drop_sat", drop_cnt, 255);
    clr     = 1'b1;
    in_stb  = 1'b1;
    in_addr = rnd_oor();
    step();
    clr     = 1'b0;
    in_stb  = 1'b0;
    check("clr_drop", drop_cnt, 0);
    check("clr_valid", cmd_valid, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cmd_ready = ($urandom_range(0, 9) < 7);
      clr       = ($urandom_range(0, 199) == 0);
      in_stb    = ($urandom_range(0, 9) < 6);
      in_data   = rnd48();
      if ($urandom_range(0, 15) == 0)
        in_addr = LAST;
      else if ($urandom_range(0, 9) == 0)
        in_addr = rnd_oor();
      else
        in_addr = 18'($urandom_range(0, LIMIT - 1));
      step();
    end
    in_stb = 1'b0;
    clr    = 1'b0;

    // Async reset while a command is held.
    cmd_ready = 1'b0;
    idle(12);
    strobe(18'd42, rnd48());
    strobe(18'd43, rnd48());
    idle(2);
    check("pre_rst_valid", cmd_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst", cmd_valid, 0);
    model_reset();
    idle(2);
    reset     = 1'b1;
    cmd_ready = 1'b1;
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
